// File: rtl/envelope_gen_pkg.sv
// Shared synth constants: tone/period settings and envelope state encodings.
package envelope_gen_pkg;

    // Tone and period constants shared by the voice generators.
    localparam int TONE_VOICES = 4;
    localparam int PERIOD_W    = 12;

    // Envelope level ceiling; level is an 8-bit unsigned quantity.
    localparam int LEVEL_MAX = 255;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_e;

    // A zero step means "jump the whole range in one tick".
    function automatic logic [7:0] eff_step(input logic [7:0] step);
        return (step == 8'd0) ? 8'(LEVEL_MAX) : step;
    endfunction

endpackage

// File: rtl/envelope_gen_scale.sv
// Combinational amplitude scaling: samp * (level + 1) >> 8.
module env_scale
    import envelope_gen_pkg::*;
#(
    parameter int SAMPLE_W = 8
) (
    input  logic [SAMPLE_W-1:0] i_samp,
    input  logic [7:0]          i_level,
    output logic [SAMPLE_W-1:0] o_scaled
);

    logic [8:0]          w_gain;
    logic [SAMPLE_W+8:0] w_prod;
    logic [SAMPLE_W+8:0] w_shifted;

    // level + 1 spans 1..256, so level 255 is an exact pass-through.
    assign w_gain    = {1'b0, i_level} + 9'd1;
    assign w_prod    = {9'd0, i_samp} * {{SAMPLE_W{1'b0}}, w_gain};
    assign w_shifted = w_prod >> 8;
    // The shifted product never exceeds i_samp, so truncation is lossless.
    assign o_scaled  = SAMPLE_W'(w_shifted);

endmodule

// File: rtl/envelope_gen.sv
// ADSR envelope generator with legato retrigger and registered sample scaling.
module envelope_gen
    import envelope_gen_pkg::*;
#(
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                gate,
    input  logic                tick,
    input  logic [7:0]          attack_step,
    input  logic [7:0]          decay_step,
    input  logic [7:0]          release_step,
    input  logic [7:0]          sustain_level,
    input  logic [SAMPLE_W-1:0] samp_in,
    output logic [SAMPLE_W-1:0] samp_out,
    output logic [7:0]          level,
    output logic [2:0]          env_state,
    output logic                active
);

    env_state_e          r_state;
    env_state_e          w_nxt_state;
    logic [7:0]          r_level;
    logic [7:0]          w_nxt_level;
    logic                r_gate_q;
    logic [SAMPLE_W-1:0] r_samp_out;
    logic [SAMPLE_W-1:0] w_scaled;

    logic                w_rise;
    logic                w_fall;
    logic [8:0]          w_att_sum;
    logic [8:0]          w_dec_diff;
    logic [8:0]          w_rel_diff;

    assign w_rise = gate & ~r_gate_q;
    assign w_fall = ~gate & r_gate_q;

    // 9-bit intermediates: bit 8 flags overflow (attack) or borrow (decay/release).
    assign w_att_sum  = {1'b0, r_level} + {1'b0, eff_step(attack_step)};
    assign w_dec_diff = {1'b0, r_level} - {1'b0, eff_step(decay_step)};
    assign w_rel_diff = {1'b0, r_level} - {1'b0, eff_step(release_step)};

    // Register the gate, envelope state and level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ENV_IDLE;
            r_level  <= 8'd0;
            r_gate_q <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_level  <= w_nxt_level;
            r_gate_q <= gate;
        end
    end

    // Next state and level; gate edges win over tick so level holds on an edge cycle.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_level = r_level;
        if (w_rise) begin
            w_nxt_state = ENV_ATTACK;
        end else if (w_fall && r_state != ENV_IDLE) begin
            w_nxt_state = ENV_RELEASE;
        end else begin
            case (r_state)
                ENV_IDLE: begin
                    w_nxt_state = ENV_IDLE;
                end
                ENV_ATTACK: begin
                    if (tick) begin
                        if (w_att_sum >= 9'(LEVEL_MAX)) begin
                            w_nxt_level = 8'(LEVEL_MAX);
                            w_nxt_state = ENV_DECAY;
                        end else begin
                            w_nxt_level = w_att_sum[7:0];
                        end
                    end
                end
                ENV_DECAY: begin
                    if (tick) begin
                        if (w_dec_diff[8] || (w_dec_diff[7:0] <= sustain_level)) begin
                            w_nxt_level = sustain_level;
                            w_nxt_state = ENV_SUSTAIN;
                        end else begin
                            w_nxt_level = w_dec_diff[7:0];
                        end
                    end
                end
                ENV_SUSTAIN: begin
                    if (tick) begin
                        w_nxt_level = sustain_level;
                    end
                end
                ENV_RELEASE: begin
                    if (tick) begin
                        if (w_rel_diff[8] || (w_rel_diff[7:0] == 8'd0)) begin
                            w_nxt_level = 8'd0;
                            w_nxt_state = ENV_IDLE;
                        end else begin
                            w_nxt_level = w_rel_diff[7:0];
                        end
                    end
                end
                default: begin
                    // Unused codes recover to a silent idle.
                    w_nxt_state = ENV_IDLE;
                    w_nxt_level = 8'd0;
                end
            endcase
        end
    end

    env_scale #(
        .SAMPLE_W (SAMPLE_W)
    ) u_scale (
        .i_samp   (samp_in),
        .i_level  (r_level),
        .o_scaled (w_scaled)
    );

    // Register the scaled sample; an idle envelope at level 0 is hard-muted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_samp_out <= '0;
        end else if (r_state == ENV_IDLE && r_level == 8'd0) begin
            r_samp_out <= '0;
        end else begin
            r_samp_out <= w_scaled;
        end
    end

    assign samp_out  = r_samp_out;
    assign level     = r_level;
    assign env_state = r_state;
    assign active    = (r_state != ENV_IDLE);

endmodule

// File: tb/tb_envelope_gen.sv
// Directed bench for envelope_gen: ADSR walk, retrigger, scaling and reset.
module tb_envelope_gen;

    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          gate;
    logic          tick;
    logic [7:0]    attack_step;
    logic [7:0]    decay_step;
    logic [7:0]    release_step;
    logic [7:0]    sustain_level;
    logic [SW-1:0] samp_in;
    logic [SW-1:0] samp_out;
    logic [7:0]    level;
    logic [2:0]    env_state;
    logic          active;

    int n_vec = 0;
    int n_err = 0;

    envelope_gen #(.SAMPLE_W(SW)) dut (
        .clk           (clk),
        .reset         (reset),
        .gate          (gate),
        .tick          (tick),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .release_step  (release_step),
        .sustain_level (sustain_level),
        .samp_in       (samp_in),
        .samp_out      (samp_out),
        .level         (level),
        .env_state     (env_state),
        .active        (active)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle tick strobe.
    task automatic tick_pulse();
        tick = 1'b1;
        clocks(1);
        tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_vec++; if (env_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", env_state); end
        n_vec++; if (level !== 8'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
        n_vec++; if (samp_out !== 8'd0) begin n_err++; $display("FAIL reset_samp: got %0d want 0", samp_out); end
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %0d want 0", active); end
        clocks(2);
        reset = 1'b1;
    endtask

    task automatic test_attack();
        int exp_lvl[4] = '{64, 128, 192, 255};
        attack_step = 8'd64;
        gate = 1'b1;
        clocks(1);
        n_vec++; if (env_state !== 3'd1) begin n_err++; $display("FAIL attack_enter: got %0d want 1", env_state); end
        n_vec++; if (level !== 8'd0) begin n_err++; $display("FAIL attack_edge_level: got %0d want 0", level); end
        for (int i = 0; i < 4; i++) begin
            clocks(3);
            tick_pulse();
            n_vec++; if (level !== 8'(exp_lvl[i])) begin n_err++; $display("FAIL attack_level%0d: got %0d want %0d", i, level, exp_lvl[i]); end
            n_vec++; if (env_state !== ((i == 3) ? 3'd2 : 3'd1)) begin n_err++; $display("FAIL attack_state%0d: got %0d want %0d", i, env_state, (i == 3) ? 2 : 1); end
        end
        // samp_out still reflects level 192: (200*193)>>8 = 150; next clock level 255 passes 200.
        n_vec++; if (samp_out !== 8'd150) begin n_err++; $display("FAIL scale_latency: got %0d want 150", samp_out); end
        clocks(1);
        n_vec++; if (samp_out !== 8'd200) begin n_err++; $display("FAIL scale_full: got %0d want 200", samp_out); end
    endtask

    task automatic test_decay_sustain();
        int exp_lvl[4] = '{205, 155, 105, 100};
        for (int i = 0; i < 4; i++) begin
            clocks(3);
            tick_pulse();
            n_vec++; if (level !== 8'(exp_lvl[i])) begin n_err++; $display("FAIL decay_level%0d: got %0d want %0d", i, level, exp_lvl[i]); end
            n_vec++; if (env_state !== ((i == 3) ? 3'd3 : 3'd2)) begin n_err++; $display("FAIL decay_state%0d: got %0d want %0d", i, env_state, (i == 3) ? 3 : 2); end
        end
        sustain_level = 8'd80;
        clocks(2);
        n_vec++; if (level !== 8'd100) begin n_err++; $display("FAIL sustain_hold: got %0d want 100", level); end
        tick_pulse();
        n_vec++; if (level !== 8'd80) begin n_err++; $display("FAIL sustain_track: got %0d want 80", level); end
    endtask

    task automatic test_scaling();
        sustain_level = 8'd127;
        tick_pulse();
        n_vec++; if (level !== 8'd127) begin n_err++; $display("FAIL scale_level127: got %0d want 127", level); end
        clocks(1);
        n_vec++; if (samp_out !== 8'd100) begin n_err++; $display("FAIL scale_half: got %0d want 100", samp_out); end
        sustain_level = 8'd80;
        tick_pulse();
        n_vec++; if (level !== 8'd80) begin n_err++; $display("FAIL sustain_back80: got %0d want 80", level); end
    endtask

    task automatic test_release();
        int exp_lvl[3] = '{50, 20, 0};
        gate = 1'b0;
        clocks(1);
        n_vec++; if (env_state !== 3'd4) begin n_err++; $display("FAIL release_enter: got %0d want 4", env_state); end
        n_vec++; if (level !== 8'd80) begin n_err++; $display("FAIL release_edge_level: got %0d want 80", level); end
        for (int i = 0; i < 3; i++) begin
            clocks(3);
            tick_pulse();
            n_vec++; if (level !== 8'(exp_lvl[i])) begin n_err++; $display("FAIL release_level%0d: got %0d want %0d", i, level, exp_lvl[i]); end
        end
        n_vec++; if (env_state !== 3'd0) begin n_err++; $display("FAIL release_idle: got %0d want 0", env_state); end
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL release_active: got %0d want 0", active); end
        clocks(1);
        n_vec++; if (samp_out !== 8'd0) begin n_err++; $display("FAIL release_mute: got %0d want 0", samp_out); end
    endtask

    task automatic test_retrigger();
        attack_step = 8'd40;
        gate = 1'b1;
        clocks(1);
        tick_pulse();
        n_vec++; if (level !== 8'd40) begin n_err++; $display("FAIL retrig_attack40: got %0d want 40", level); end
        gate = 1'b0;
        clocks(1);
        n_vec++; if (env_state !== 3'd4) begin n_err++; $display("FAIL retrig_release: got %0d want 4", env_state); end
        // Rise and tick on the same cycle: edge wins, level must not step.
        gate = 1'b1;
        tick = 1'b1;
        clocks(1);
        tick = 1'b0;
        n_vec++; if (env_state !== 3'd1) begin n_err++; $display("FAIL retrig_state: got %0d want 1", env_state); end
        n_vec++; if (level !== 8'd40) begin n_err++; $display("FAIL retrig_level: got %0d want 40", level); end
        attack_step = 8'd0;
        tick_pulse();
        n_vec++; if (level !== 8'd255) begin n_err++; $display("FAIL zero_step_level: got %0d want 255", level); end
        n_vec++; if (env_state !== 3'd2) begin n_err++; $display("FAIL zero_step_state: got %0d want 2", env_state); end
    endtask

    task automatic test_reset_mid_decay();
        decay_step    = 8'd75;
        sustain_level = 8'd0;
        tick_pulse();
        n_vec++; if (level !== 8'd180) begin n_err++; $display("FAIL middecay_level: got %0d want 180", level); end
        clocks(1);
        // (200*181)>>8 = 141
        n_vec++; if (samp_out !== 8'd141) begin n_err++; $display("FAIL middecay_samp: got %0d want 141", samp_out); end
        #3 reset = 1'b0;
        #1;
        n_vec++; if (level !== 8'd0) begin n_err++; $display("FAIL async_level: got %0d want 0", level); end
        n_vec++; if (samp_out !== 8'd0) begin n_err++; $display("FAIL async_samp: got %0d want 0", samp_out); end
        n_vec++; if (env_state !== 3'd0) begin n_err++; $display("FAIL async_state: got %0d want 0", env_state); end
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL async_active: got %0d want 0", active); end
    endtask

    task automatic test_reset_gate_high();
        clocks(2);
        n_vec++; if (env_state !== 3'd0) begin n_err++; $display("FAIL held_reset_state: got %0d want 0", env_state); end
        reset = 1'b1;
        clocks(1);
        n_vec++; if (env_state !== 3'd1) begin n_err++; $display("FAIL gate_high_attack: got %0d want 1", env_state); end
        n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL gate_high_active: got %0d want 1", active); end
    endtask

    initial begin
        gate          = 1'b0;
        tick          = 1'b0;
        attack_step   = 8'd64;
        decay_step    = 8'd50;
        release_step  = 8'd30;
        sustain_level = 8'd100;
        samp_in       = 8'd200;
        test_reset();
        test_attack();
        test_decay_sustain();
        test_scaling();
        test_release();
        test_retrigger();
        test_reset_mid_decay();
        test_reset_gate_high();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/envelope_gen.md
ENVELOPE_GEN -- requirements
Module: envelope_gen

Interface
REQ-001 The block SHALL have parameter SAMPLE_W, default 8, meaning the width of samp_in and samp_out.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port gate, input, 1, note-on level: high = key held, low = key released.
REQ-005 The block SHALL have port tick, input, 1, one-cycle envelope-rate strobe; level changes only on cycles where tick=1.
REQ-006 The block SHALL have ports attack_step, decay_step, release_step, input, 8 each, level increment or decrement applied per tick.
REQ-007 The block SHALL have port sustain_level, input, 8, the target level held in SUSTAIN.
REQ-008 The block SHALL have port samp_in, input, SAMPLE_W, unsigned voice sample (e.g. a square_amp output).
REQ-009 The block SHALL have port samp_out, output, SAMPLE_W, unsigned enveloped sample, registered.
REQ-010 The block SHALL have port level, output, 8, current envelope level, registered.
REQ-011 The block SHALL have port env_state, output, 3, current state encoding.
REQ-012 The block SHALL have port active, output, 1, high whenever env_state != IDLE.

Function
REQ-013 States SHALL be IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; codes 5-7 SHALL return to IDLE on the next clock.
REQ-014 gate SHALL be registered once (gate_q); rise = gate & ~gate_q, fall = ~gate & gate_q.
REQ-015 On rise, from any state, the next state SHALL be ATTACK and level SHALL be kept (no restart from 0, legato retrigger).
REQ-016 On fall, from any state other than IDLE, the next state SHALL be RELEASE with level kept.
REQ-017 If an edge and tick coincide, the edge transition SHALL take effect and level SHALL NOT step that cycle.
REQ-018 In ATTACK on tick, level SHALL become min(level + attack_step, 255); when the result is 255, the state SHALL become DECAY in the same update.
REQ-019 In DECAY on tick, level SHALL become max(level - decay_step, sustain_level); when the result equals sustain_level, the state SHALL become SUSTAIN.
REQ-020 In SUSTAIN on tick, level SHALL be loaded with sustain_level, so live changes to sustain_level are tracked.
REQ-021 In RELEASE on tick, level SHALL become max(level - release_step, 0); when the result is 0, the state SHALL become IDLE.
REQ-022 A step input of 0 SHALL be treated as 255, giving an instant transition in one tick.
REQ-023 If sustain_level = 255, DECAY SHALL exit to SUSTAIN on its first tick; if sustain_level = 0, SUSTAIN SHALL be silent while gate stays high.
REQ-024 All saturation SHALL use 9-bit intermediates; level SHALL never wrap.
REQ-025 samp_out SHALL be registered as (samp_in * (level + 1)) >> 8, with a 1-clock latency from samp_in and level; level=255 passes samp_in unchanged, and level=0 with state IDLE forces samp_out=0.
REQ-026 tick, gate and step inputs SHALL be sampled every clock with no handshake; there is no back-pressure.

Reset
REQ-027 While reset=0, the block SHALL force env_state=IDLE, level=0, samp_out=0, gate_q=0 and active=0, asynchronously.
REQ-028 After reset deasserts with gate already high, the next clock SHALL detect a rise and enter ATTACK.
REQ-029 Reset asserted mid-ATTACK/DECAY/RELEASE SHALL abort the envelope immediately, with no release tail.

Structure
REQ-030 The state encodings and the LEVEL_MAX=255 constant SHALL live in the shared synth package alongside the existing tone and period constants.
REQ-031 The scaling multiply SHALL be one sub-module, env_scale (combinational samp_in × (level+1) >> 8), registered in envelope_gen.
REQ-032 One envelope_gen instance SHALL be placed per voice between the square_amp/noise_gen output and mix4, with tick derived from the slow-clock domain.

Verification
REQ-033 Attack: gate 0→1, attack_step=64, tick every 4 clocks -> level 64,128,192,255; DECAY is entered on the 4th tick.
REQ-034 Decay and sustain: decay_step=50, sustain_level=100 -> level 205,155,105,100; SUSTAIN is entered; sustain_level changed to 80 -> level=80 on the next tick.
REQ-035 Release: gate 1→0 at level 80, release_step=30 -> 50,20,0, then IDLE and active=0; samp_in=200 gives samp_out=0.
REQ-036 Edge cases: gate rise coincident with tick at level 40 in RELEASE -> ATTACK entered, level stays 40 that cycle; attack_step=0 -> level 255 on the first tick.
REQ-037 Scaling: samp_in=200 with level=255 -> samp_out=200; with level=127 -> samp_out=100, one clock after level settles.
REQ-038 Reset: assert reset=0 mid-DECAY at level 180 -> level=0, samp_out=0 and env_state=IDLE without waiting for clk.
